// File: rtl/msg_rotator_7seg.sv
// Message rotator: loads 2-bit chars into a buffer, then scrolls a 4-digit 7-seg window over it.
// Latency: offset/state change on the edge after the deciding cycle; codes are registered one clock behind offset.
// Backpressure: load_ready is high only in IDLE; chars offered while it is low are silently dropped.
module msg_rotator_7seg #(
  parameter int MSG_LEN  = 5,
  parameter int TICK_DIV = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_valid,
  input  logic [1:0]                 load_char,
  output logic                       load_ready,
  input  logic                       start,
  input  logic                       pause,
  input  logic                       dir,
  input  logic                       clear,
  output logic [6:0]                 code1,
  output logic [6:0]                 code2,
  output logic [6:0]                 code3,
  output logic [6:0]                 code4,
  output logic [$clog2(MSG_LEN)-1:0] offset,
  output logic                       busy
);

  localparam int OW  = $clog2(MSG_LEN);
  localparam int OW1 = OW + 1;
  localparam int TW  = $clog2(TICK_DIV);

  localparam logic [OW-1:0] LAST_IDX  = OW'(MSG_LEN - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [6:0]    BLANK     = 7'b1111111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READY,
    S_RUN,
    S_PAUSE
  } state_t;

  state_t          state_q, state_d;
  logic [OW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [OW-1:0]   offset_q, offset_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic            wr_en;
  logic [1:0]      char_buf [MSG_LEN];
  logic [6:0]      code_q [4];
  logic [6:0]      code_d [4];

  // Character code to active-low {g,f,e,d,c,b,a} pattern.
  function automatic logic [6:0] seg7(input logic [1:0] c);
    logic [6:0] s;
    case (c)
      2'b00:   s = 7'b0001001; // H
      2'b01:   s = 7'b0000110; // E
      2'b10:   s = 7'b1000111; // L
      default: s = 7'b1000000; // O
    endcase
    return s;
  endfunction

  // (base + k) mod MSG_LEN with one extra bit of headroom, so non-power-of-2
  // lengths never rely on natural binary wrap.
  function automatic logic [OW-1:0] wrap_idx(input logic [OW-1:0] base, input int k);
    logic [OW:0] s;
    s = {1'b0, base} + OW1'(k);
    if (s >= OW1'(MSG_LEN)) s = s - OW1'(MSG_LEN);
    return s[OW-1:0];
  endfunction

  // Next-state and control decode; clear outranks pause, which outranks start.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    offset_d   = offset_q;
    tick_d     = tick_q;
    wr_en      = 1'b0;
    load_ready = (state_q == S_IDLE);
    busy       = (state_q == S_RUN);

    if (clear) begin
      state_d  = S_IDLE;
      wr_ptr_d = '0;
      offset_d = '0;
      tick_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (load_valid) begin
            wr_en = 1'b1;
            if (wr_ptr_q == LAST_IDX) begin
              wr_ptr_d = '0;
              state_d  = S_READY;
            end else begin
              wr_ptr_d = wr_ptr_q + OW'(1);
            end
          end
        end
        S_READY: begin
          if (!pause && start) begin
            state_d = S_RUN;
            tick_d  = '0;
          end
        end
        S_RUN: begin
          // A pause on the step cycle wins: the step is deferred, not lost.
          if (pause) begin
            state_d = S_PAUSE;
          end else if (tick_q == TICK_LAST) begin
            tick_d = '0;
            if (dir) offset_d = (offset_q == '0) ? LAST_IDX : offset_q - OW'(1);
            else     offset_d = (offset_q == LAST_IDX) ? '0 : offset_q + OW'(1);
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        S_PAUSE: begin
          if (!pause && start) state_d = S_RUN;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Window decode from the current offset; blank in IDLE and on the clear edge.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      if (clear || state_q == S_IDLE) code_d[k] = BLANK;
      else                            code_d[k] = seg7(char_buf[wrap_idx(offset_q, k)]);
    end
  end

  // Control state registers and registered display codes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      offset_q <= '0;
      tick_q   <= '0;
      for (int k = 0; k < 4; k++) code_q[k] <= BLANK;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      offset_q <= offset_d;
      tick_q   <= tick_d;
      for (int k = 0; k < 4; k++) code_q[k] <= code_d[k];
    end
  end

  // Message buffer: no reset, a full load always rewrites every entry.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) char_buf[wr_ptr_q] <= load_char;
  end

  assign code1  = code_q[0];
  assign code2  = code_q[1];
  assign code3  = code_q[2];
  assign code4  = code_q[3];
  assign offset = offset_q;

endmodule

// File: tb/tb_msg_rotator_7seg.sv
// Bench for msg_rotator_7seg: directed vector table, hand sequences for
// multi-cycle corners, then randomized traffic against a behavioural model.
module tb_msg_rotator_7seg;

  localparam int L  = 5;
  localparam int TD = 4;

  localparam logic [6:0] SH = 7'b0001001;
  localparam logic [6:0] SE = 7'b0000110;
  localparam logic [6:0] SL = 7'b1000111;
  localparam logic [6:0] SO = 7'b1000000;
  localparam logic [6:0] SB = 7'b1111111;

  localparam int MI = 0; // idle / loading
  localparam int MR = 1; // ready
  localparam int MN = 2; // running
  localparam int MP = 3; // paused

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset, load_valid, load_ready, start, pause, dir, clear, busy;
  logic [1:0]           load_char;
  logic [6:0]           code1, code2, code3, code4;
  logic [$clog2(L)-1:0] offset;

  msg_rotator_7seg #(.MSG_LEN(L), .TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_char(load_char),
    .load_ready(load_ready), .start(start), .pause(pause), .dir(dir), .clear(clear),
    .code1(code1), .code2(code2), .code3(code3), .code4(code4),
    .offset(offset), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: message as an int array, window position as plain ints.
  int         m_mode = MI;
  int         m_wr   = 0;
  int         m_off  = 0;
  int         m_tick = 0;
  int         m_msg [L];
  logic [6:0] m_code [4];

  typedef struct {
    bit lv; int ch; bit st; bit pa; bit di; bit cl;
    logic [6:0] c1, c2, c3, c4;
    int off; bit bz; bit rd;
  } vec_t;

  vec_t tbl [16];

  function automatic logic [6:0] seg_of(input int c);
    case (c)
      0:       return SH;
      1:       return SE;
      2:       return SL;
      default: return SO;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit lv, input int ch, input bit st,
                            input bit pa, input bit di, input bit cl);
    for (int k = 0; k < 4; k++)
      m_code[k] = (r || cl || m_mode == MI) ? SB : seg_of(m_msg[(m_off + k) % L]);
    if (r || cl) begin
      m_mode = MI; m_wr = 0; m_off = 0; m_tick = 0;
    end else begin
      case (m_mode)
        MI: if (lv) begin
          m_msg[m_wr] = ch;
          m_wr++;
          if (m_wr == L) begin m_mode = MR; m_wr = 0; end
        end
        MR: if (!pa && st) begin m_mode = MN; m_tick = 0; end
        MN: begin
          if (pa) m_mode = MP;
          else if (m_tick == TD - 1) begin
            m_tick = 0;
            m_off  = di ? (m_off + L - 1) % L : (m_off + 1) % L;
          end else m_tick++;
        end
        default: if (!pa && st) m_mode = MN;
      endcase
    end
  endtask

  task automatic compare_model();
    chk("code1", code1, m_code[0]);
    chk("code2", code2, m_code[1]);
    chk("code3", code3, m_code[2]);
    chk("code4", code4, m_code[3]);
    chk("offset", offset, m_off);
    chk("busy", busy, m_mode == MN);
    chk("load_ready", load_ready, m_mode == MI);
  endtask

  task automatic cyc(input bit r, input bit lv, input int ch, input bit st,
                     input bit pa, input bit di, input bit cl, input bit cmp);
    reset = r; load_valid = lv; load_char = ch[1:0];
    start = st; pause = pa; dir = di; clear = cl;
    @(posedge clk);
    model_step(r, lv, ch, st, pa, di, cl);
    #1;
    if (cmp) compare_model();
  endtask

  task automatic idle(input int n, input bit di);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, di, 0, 1);
  endtask

  task automatic chk_codes(input string nm, input logic [6:0] a, input logic [6:0] b,
                           input logic [6:0] c, input logic [6:0] d);
    chk({nm, "_c1"}, code1, a);
    chk({nm, "_c2"}, code2, b);
    chk({nm, "_c3"}, code3, c);
    chk({nm, "_c4"}, code4, d);
  endtask

  initial begin
    reset = 1'b1; load_valid = 1'b0; load_char = 2'b00;
    start = 1'b0; pause = 1'b0; dir = 1'b0; clear = 1'b0;

    //             lv ch st pa di cl  c1 c2 c3 c4 off bz rd
    tbl[0]  = '{1, 0, 0, 0, 0, 0, SB, SB, SB, SB, 0, 0, 1};
    tbl[1]  = '{1, 1, 0, 0, 0, 0, SB, SB, SB, SB, 0, 0, 1};
    tbl[2]  = '{1, 2, 0, 0, 0, 0, SB, SB, SB, SB, 0, 0, 1};
    tbl[3]  = '{1, 2, 0, 0, 0, 0, SB, SB, SB, SB, 0, 0, 1};
    tbl[4]  = '{1, 3, 0, 0, 0, 0, SB, SB, SB, SB, 0, 0, 0};
    tbl[5]  = '{1, 0, 0, 0, 0, 0, SH, SE, SL, SL, 0, 0, 0};
    tbl[6]  = '{0, 0, 1, 0, 0, 0, SH, SE, SL, SL, 0, 1, 0};
    tbl[7]  = '{0, 0, 0, 0, 0, 0, SH, SE, SL, SL, 0, 1, 0};
    tbl[8]  = '{0, 0, 0, 0, 0, 0, SH, SE, SL, SL, 0, 1, 0};
    tbl[9]  = '{0, 0, 0, 0, 0, 0, SH, SE, SL, SL, 0, 1, 0};
    tbl[10] = '{0, 0, 0, 0, 0, 0, SH, SE, SL, SL, 1, 1, 0};
    tbl[11] = '{0, 0, 0, 0, 0, 0, SE, SL, SL, SO, 1, 1, 0};
    tbl[12] = '{0, 0, 0, 0, 0, 0, SE, SL, SL, SO, 1, 1, 0};
    tbl[13] = '{0, 0, 0, 0, 0, 0, SE, SL, SL, SO, 1, 1, 0};
    tbl[14] = '{0, 0, 0, 0, 0, 0, SE, SL, SL, SO, 2, 1, 0};
    tbl[15] = '{0, 0, 0, 0, 0, 0, SL, SL, SO, SH, 2, 1, 0};

    // Reset state
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk_codes("reset", SB, SB, SB, SB);
    chk("reset_ready", load_ready, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_off", offset, 0);

    // Load HELL(O), ignored 6th char, start and first two steps
    for (int i = 0; i < 16; i++) begin
      cyc(0, tbl[i].lv, tbl[i].ch, tbl[i].st, tbl[i].pa, tbl[i].di, tbl[i].cl, 0);
      chk_codes($sformatf("vec%0d", i), tbl[i].c1, tbl[i].c2, tbl[i].c3, tbl[i].c4);
      chk($sformatf("vec%0d_off", i), offset, tbl[i].off);
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].bz);
      chk($sformatf("vec%0d_rdy", i), load_ready, tbl[i].rd);
    end

    // Wrap back to offset 0 shows HELL again
    for (int n = 0; n < 40 && !(m_off == 0 && m_tick == 1); n++) idle(1, 0);
    chk("wrap_off", offset, 0);
    chk_codes("wrap", SH, SE, SL, SL);

    // Pause for 10 clocks (start held on some, ignored); resume keeps tick
    idle(1, 0);
    for (int n = 0; n < 10; n++) cyc(0, 0, 0, n % 2, 1, 0, 0, 1);
    chk("pause_off", offset, 0);
    chk("pause_busy", busy, 1'b0);
    chk_codes("pause", SH, SE, SL, SL);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    chk("pause_nostart_busy", busy, 1'b0);
    cyc(0, 0, 0, 1, 0, 0, 0, 1);
    chk("resume_busy", busy, 1'b1);
    idle(1, 0);
    chk("resume_off_hold", offset, 0);
    idle(1, 0);
    chk("resume_step", offset, 1);

    // clear together with start in RUN
    cyc(0, 0, 0, 1, 0, 0, 1, 1);
    chk_codes("clear", SB, SB, SB, SB);
    chk("clear_ready", load_ready, 1'b1);
    chk("clear_busy", busy, 1'b0);
    chk("clear_off", offset, 0);

    // Reverse direction from READY
    cyc(0, 1, 0, 0, 0, 0, 0, 1);
    cyc(0, 1, 1, 0, 0, 0, 0, 1);
    cyc(0, 1, 2, 0, 0, 0, 0, 1);
    cyc(0, 1, 2, 0, 0, 0, 0, 1);
    cyc(0, 1, 3, 0, 0, 0, 0, 1);
    idle(1, 1);
    cyc(0, 0, 0, 1, 0, 1, 0, 1);
    idle(4, 1);
    chk("dir1_off4", offset, 4);
    idle(1, 1);
    chk_codes("dir1_ohel", SO, SH, SE, SL);
    idle(3, 1);
    chk("dir1_off3", offset, 3);
    idle(1, 1);
    chk_codes("dir1_lohe", SL, SO, SH, SE);

    // Partial load discarded by clear, then OOOOO rotates invisibly
    cyc(0, 0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) cyc(0, 1, 3, 0, 0, 0, 0, 1);
    chk("partial_discard_rdy", load_ready, 1'b1);
    cyc(0, 1, 3, 0, 0, 0, 0, 1);
    chk("full_load_rdy", load_ready, 1'b0);
    idle(1, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 1);
    for (int i = 0; i < 12; i++) begin
      idle(1, 0);
      chk_codes($sformatf("oooo%0d", i), SO, SO, SO, SO);
    end

    // Randomized traffic against the model
    begin
      bit pa_lvl;
      pa_lvl = 1'b0;
      for (int n = 0; n < 3000; n++) begin
        if ($urandom_range(0, 11) == 0) pa_lvl = ~pa_lvl;
        cyc($urandom_range(0, 299) == 0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
            $urandom_range(0, 3) == 0, pa_lvl, 1'($urandom_range(0, 1)),
            $urandom_range(0, 59) == 0, 1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
